// File: rtl/miriscv_lsu_pkg.sv
// Shared encodings for the LSU request pipe: memory access sizes and request FSM states.
package miriscv_lsu_pkg;

  localparam int MEM_ACCESS_W = 3;

  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = 3'd0;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = 3'd1;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = 3'd2;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_DWORD = 3'd3;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = 3'd4;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = 3'd5;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UWORD = 3'd6;

  typedef enum logic {
    LSU_IDLE     = 1'b0,
    LSU_WAIT_GNT = 1'b1
  } lsu_req_state_e;

  // 64-bit accesses (DWORD, and UWORD which only exists to zero-extend) need XLEN=64.
  function automatic logic mem_size_legal(input logic [MEM_ACCESS_W-1:0] size, input int xlen);
    case (size)
      MEM_ACCESS_BYTE, MEM_ACCESS_HALF, MEM_ACCESS_WORD,
      MEM_ACCESS_UBYTE, MEM_ACCESS_UHALF: mem_size_legal = 1'b1;
      MEM_ACCESS_DWORD, MEM_ACCESS_UWORD: mem_size_legal = (xlen == 64);
      default:                            mem_size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_req_pipe_if.sv
// Data-memory request bus (req/gnt/rvalid). master = LSU side, slave = memory side.
interface miriscv_lsu_req_pipe_if #(
  parameter int XLEN = 32
);

  logic              data_req;
  logic              data_we;
  logic [XLEN/8-1:0] data_be;
  logic [XLEN-1:0]   data_addr;
  logic [XLEN-1:0]   data_wdata;
  logic              data_gnt;
  logic              data_rvalid;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid
  );

endinterface

// File: rtl/miriscv_lsu_align.sv
// Combinational byte-enable, lane rotation and misalignment detection for one access.
// Misalignment is only reported when MIRISCV_LSU_MISALIGN_TRAP_EN is defined.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [MEM_ACCESS_W-1:0]   size_i,
  input  logic [$clog2(XLEN/8)-1:0] offset_i,
  input  logic [XLEN-1:0]           wdata_i,
  output logic [XLEN/8-1:0]         be_o,
  output logic [XLEN-1:0]           wdata_o,
  output logic                      legal_o,
  output logic                      misaligned_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  logic [3:0]          nbytes;
  logic [15:0]         be_wide;
  logic [OFF_W+2:0]    rot_amt;
  logic [2*XLEN-1:0]   wdata_dbl;

  assign legal_o = mem_size_legal(size_i, XLEN);
  assign nbytes  = 4'd1 << size_i[1:0];

  // Enables shifted past the top lane are simply dropped (truncated be).
  assign be_wide = ((16'd1 << nbytes) - 16'd1) << offset_i;
  assign be_o    = legal_o ? be_wide[NB-1:0] : '0;

  assign rot_amt   = {offset_i, 3'b000};
  assign wdata_dbl = {wdata_i, wdata_i} << rot_amt;
  assign wdata_o   = wdata_dbl[2*XLEN-1:XLEN];

`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
  logic [3:0] offset_ext;
  assign offset_ext   = 4'(offset_i);
  assign misaligned_o = legal_o && ((offset_ext & (nbytes - 4'd1)) != 4'd0);
`else
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/miriscv_lsu_req_pipe.sv
// E->M register stage that issues data-memory requests, holds them until granted and tracks in-flight responses.
// Misalignment trapping is enabled by defining MIRISCV_LSU_MISALIGN_TRAP_EN.
module miriscv_lsu_req_pipe
  import miriscv_lsu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic                      cu_kill_m_i,
  input  logic                      cu_stall_m_i,
  output logic                      m_stall_req_o,
  input  logic                      e_valid_i,
  input  logic                      e_mem_req_i,
  input  logic                      e_mem_we_i,
  input  logic [MEM_ACCESS_W-1:0]   e_mem_size_i,
  input  logic [XLEN-1:0]           e_mem_addr_i,
  input  logic [XLEN-1:0]           e_mem_data_i,
  miriscv_lsu_req_pipe_if.master    data_bus,
  output logic                      m_valid_o,
  output logic                      m_mem_req_o,
  output logic [MEM_ACCESS_W-1:0]   m_mem_size_o,
  output logic [$clog2(XLEN/8)-1:0] m_mem_addr_o,
  output logic                      m_misaligned_o,
  output logic                      lsu_busy_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  lsu_req_state_e   state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_we_q;
  logic [NB-1:0]    hold_be_q;
  logic [XLEN-1:0]  hold_addr_q, hold_wdata_q;

  logic                    m_valid_q, m_mem_req_q, m_misaligned_q;
  logic [MEM_ACCESS_W-1:0] m_mem_size_q;
  logic [OFF_W-1:0]        m_mem_addr_q;

  logic [NB-1:0]   e_be;
  logic [XLEN-1:0] e_wdata;
  logic            e_legal, e_misaligned;
  logic [CNT_W:0]  occupancy;
  logic            wait_gnt, full, e_mem_op, issue, bus_fire, resp;

  miriscv_lsu_align #(.XLEN(XLEN)) u_align (
    .size_i       (e_mem_size_i),
    .offset_i     (e_mem_addr_i[OFF_W-1:0]),
    .wdata_i      (e_mem_data_i),
    .be_o         (e_be),
    .wdata_o      (e_wdata),
    .legal_o      (e_legal),
    .misaligned_o (e_misaligned)
  );

  assign wait_gnt  = (state_q == LSU_WAIT_GNT);
  // A request parked in WAIT_GNT will consume a slot once granted, so it counts as occupied.
  assign occupancy = {1'b0, cnt_q} + (CNT_W+1)'(wait_gnt);
  assign full      = (occupancy == (CNT_W+1)'(MAX_OUTSTANDING));
  assign e_mem_op  = e_valid_i & e_mem_req_i;
  assign issue     = !wait_gnt && e_mem_op && !cu_kill_m_i && !cu_stall_m_i
                     && !full && !e_misaligned && e_legal;

  assign data_bus.data_req   = wait_gnt | issue;
  assign data_bus.data_we    = wait_gnt ? hold_we_q    : e_mem_we_i;
  assign data_bus.data_be    = wait_gnt ? hold_be_q    : e_be;
  assign data_bus.data_addr  = wait_gnt ? hold_addr_q  : e_mem_addr_i;
  assign data_bus.data_wdata = wait_gnt ? hold_wdata_q : e_wdata;

  // Depends only on state and E inputs, never on data_gnt.
  assign m_stall_req_o = wait_gnt | (e_mem_op & full);
  assign lsu_busy_o    = wait_gnt | (cnt_q != '0);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= LSU_IDLE;
      hold_we_q    <= 1'b0;
      hold_be_q    <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (issue && !data_bus.data_gnt) begin
            state_q      <= LSU_WAIT_GNT;
            hold_we_q    <= e_mem_we_i;
            hold_be_q    <= e_be;
            hold_addr_q  <= e_mem_addr_i;
            hold_wdata_q <= e_wdata;
          end
        end
        LSU_WAIT_GNT: begin
          if (data_bus.data_gnt) begin
            state_q <= LSU_IDLE;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign bus_fire = data_bus.data_req & data_bus.data_gnt;
  assign resp     = data_bus.data_rvalid & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (bus_fire && !resp) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!bus_fire && resp) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // While waiting for grant M holds the committed memory op, so kill cannot remove it.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_valid_q      <= 1'b0;
      m_mem_req_q    <= 1'b0;
      m_mem_size_q   <= '0;
      m_mem_addr_q   <= '0;
      m_misaligned_q <= 1'b0;
    end else if (!wait_gnt) begin
      if (cu_kill_m_i) begin
        m_valid_q <= 1'b0;
      end else if (!cu_stall_m_i) begin
        m_valid_q <= e_valid_i;
      end
      if (e_valid_i && !cu_stall_m_i) begin
        m_mem_req_q    <= e_mem_req_i;
        m_mem_size_q   <= e_mem_size_i;
        m_mem_addr_q   <= e_mem_addr_i[OFF_W-1:0];
        m_misaligned_q <= e_mem_req_i & e_misaligned;
      end
    end
  end

  assign m_valid_o      = m_valid_q;
  assign m_mem_req_o    = m_mem_req_q;
  assign m_mem_size_o   = m_mem_size_q;
  assign m_mem_addr_o   = m_mem_addr_q;
  assign m_misaligned_o = m_misaligned_q;

endmodule
